wave_dispatcher: RTL and testbench
==================================

WAVE_DISPATCHER -- requirements
Module: wave_dispatcher

Interface
REQ-001 SHALL have parameter NUM_SIMDS, default 4: number of SIMD units fed.
REQ-002 SHALL have parameter WAVE_SIZE, default 32: threads per wavefront.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port enable, input, 1: high permits new wave issue; low stalls issue only.
REQ-006 SHALL have port block_start, input, 1: one-cycle request to run a block; accepted only when block_ready=1.
REQ-007 SHALL have port block_id_in, input, 32: id of the block being started, captured on accept.
REQ-008 SHALL have port block_dim, input, 32: threads in the block, captured on accept.
REQ-009 SHALL have port block_ready, output, 1: dispatcher idle and able to accept.
REQ-010 SHALL have port block_done, output, 1: one-cycle pulse when every wave of the block has completed.
REQ-011 SHALL have port simd_done, input, NUM_SIMDS: bit i is SIMD i's completion flag.
REQ-012 SHALL have ports simd_ready, simd_start, simd_working, output, NUM_SIMDS each: per-SIMD state flags, exactly one set per SIMD.
REQ-013 SHALL have port wave_id, output, 32*NUM_SIMDS: slice i is the wave assigned to SIMD i.
REQ-014 SHALL have ports block_id and num_waves_in_block, output, 32 each: the captured block id and the computed wave count, common to all SIMDs.
REQ-015 SHALL have port perf_dispatch_cycles, output, 32: busy-cycle counter (see Configuration).

Function
REQ-016 Block FSM SHALL have states IDLE, DISPATCH and DRAIN; block_ready=1 only in IDLE.
REQ-017 IDLE with block_start=1 SHALL capture block_id_in and block_dim, set num_waves_in_block=ceil(block_dim/WAVE_SIZE), clear the issued and completed counters, and go to DISPATCH next cycle.
REQ-018 block_start SHALL be ignored outside IDLE.
REQ-019 block_dim=0 SHALL give num_waves_in_block=0; the FSM SHALL go IDLE->DISPATCH->IDLE and pulse block_done in the DISPATCH cycle without issuing any wave.
REQ-020 Per-SIMD FSM SHALL have states READY, START and WORKING; the outputs simd_ready, simd_start and simd_working SHALL be the one-hot decode of this state.
REQ-021 In DISPATCH with enable=1 and issued<num_waves, the lowest-index SIMD in READY SHALL be assigned wave_id=issued and enter START next cycle; issued SHALL increment by 1.
REQ-022 At most one wave SHALL be issued per cycle.
REQ-023 START SHALL last exactly one cycle, then go to WORKING.
REQ-024 WORKING with simd_done[i]=1 SHALL go to READY next cycle and increment completed by 1.
REQ-025 simd_done[i] in READY or START SHALL be ignored.
REQ-026 A SIMD that receives done in cycle t SHALL NOT be eligible for issue until cycle t+1.
REQ-027 When issued==num_waves, the block FSM SHALL move DISPATCH->DRAIN.
REQ-028 When completed==num_waves in DRAIN, block_done SHALL pulse for 1 cycle and the FSM SHALL return to IDLE on the same edge.
REQ-029 enable=0 SHALL block issue only; done handling and the DRAIN exit SHALL continue.
REQ-030 wave_id slice i SHALL hold its value until SIMD i's next issue.

Reset
REQ-031 rst=1 SHALL force block FSM=IDLE, every SIMD FSM=READY, counters=0, wave_id/block_id/num_waves_in_block=0, block_done=0 and perf_dispatch_cycles=0.
REQ-032 The reset values SHALL give block_ready=1 and simd_ready=all ones.
REQ-033 Reset mid-block SHALL abandon all in-flight waves with no block_done pulse.

Configuration
REQ-034 With WAVE_DISPATCH_PERF_EN defined, perf_dispatch_cycles SHALL increment on every cycle the block FSM is not IDLE and SHALL saturate at 0xFFFFFFFF; it is cleared only by rst.
REQ-035 Without WAVE_DISPATCH_PERF_EN, perf_dispatch_cycles SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-036 block_dim=64, NUM_SIMDS=4 -> num_waves_in_block=2; SIMD0 is given wave 0 and SIMD1 wave 1 on consecutive cycles; done on both -> one block_done pulse.
REQ-037 block_dim=33 -> num_waves_in_block=2; block_dim=0 -> block_done 2 cycles after block_start, simd_start never asserted.
REQ-038 block_dim=192 (6 waves) -> waves 0-3 go to SIMD0-3; simd_done[2] then simd_done[0] -> wave 4 goes to SIMD2, wave 5 to SIMD0.
REQ-039 enable=0 held for 5 cycles in DISPATCH -> no simd_start and issued unchanged; WORKING SIMDs still return to READY on done.
REQ-040 rst asserted while 2 waves are WORKING -> next cycle all simd_ready=1, block_ready=1, no block_done; block_start during DRAIN is ignored.
REQ-041 With WAVE_DISPATCH_PERF_EN, a block taking 10 non-IDLE cycles -> perf_dispatch_cycles=10; without the macro it reads 0.

Source files
------------

// File: rtl/wave_dispatcher.sv
// wave_dispatcher: splits a thread block into wavefronts and issues them to the lowest free SIMD.
// Define WAVE_DISPATCH_PERF_EN to build the saturating busy-cycle counter on perf_dispatch_cycles.
module wave_dispatcher #(
  parameter int NUM_SIMDS = 4,
  parameter int WAVE_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    block_start,
  input  logic [31:0]             block_id_in,
  input  logic [31:0]             block_dim,
  output logic                    block_ready,
  output logic                    block_done,
  input  logic [NUM_SIMDS-1:0]    simd_done,
  output logic [NUM_SIMDS-1:0]    simd_ready,
  output logic [NUM_SIMDS-1:0]    simd_start,
  output logic [NUM_SIMDS-1:0]    simd_working,
  output logic [32*NUM_SIMDS-1:0] wave_id,
  output logic [31:0]             block_id,
  output logic [31:0]             num_waves_in_block,
  output logic [31:0]             perf_dispatch_cycles
);
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} blk_e;
  typedef enum logic [1:0] {S_READY, S_START, S_WORKING} simd_e;
  blk_e        state_q;
  simd_e       simd_q [NUM_SIMDS];
  logic [31:0] wave_q [NUM_SIMDS];
  logic [31:0] issued_q, completed_q, completed_d, num_q, bid_q;
  logic        done_q;
  logic [32:0] dim_up;
  logic [31:0] num_calc;
  logic [NUM_SIMDS-1:0] grant, issue_oh, done_hit;
  logic        can_issue;
  // 33-bit round-up so block_dim near 2^32 cannot wrap
  assign dim_up      = {1'b0, block_dim} + 33'(WAVE_SIZE - 1);
  assign num_calc    = 32'(dim_up / 33'(WAVE_SIZE));
  assign grant       = simd_ready & (~simd_ready + NUM_SIMDS'(1));
  assign can_issue   = state_q == DISPATCH && enable && issued_q < num_q;
  assign issue_oh    = can_issue ? grant : '0;
  assign done_hit    = simd_done & simd_working;
  assign completed_d = completed_q + 32'($countones(done_hit));
  assign block_ready = state_q == IDLE;
  assign block_done  = done_q;
  assign block_id    = bid_q;
  assign num_waves_in_block = num_q;
  always_comb begin
    simd_ready   = '0;
    simd_start   = '0;
    simd_working = '0;
    wave_id      = '0;
    for (int i = 0; i < NUM_SIMDS; i++) begin
      simd_ready[i]        = simd_q[i] == S_READY;
      simd_start[i]        = simd_q[i] == S_START;
      simd_working[i]      = simd_q[i] == S_WORKING;
      wave_id[32*i +: 32]  = wave_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      completed_q <= '0;
      num_q       <= '0;
      bid_q       <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_SIMDS; i++) begin
        simd_q[i] <= S_READY;
        wave_q[i] <= '0;
      end
    end else begin
      done_q      <= 1'b0;
      completed_q <= completed_d;
      if (|issue_oh) issued_q <= issued_q + 32'd1;
      for (int i = 0; i < NUM_SIMDS; i++) begin
        if (issue_oh[i]) begin
          simd_q[i] <= S_START;
          wave_q[i] <= issued_q;
        end else if (simd_q[i] == S_START) simd_q[i] <= S_WORKING;
        else if (done_hit[i]) simd_q[i] <= S_READY;
      end
      if (state_q == IDLE && block_start) begin
        bid_q       <= block_id_in;
        num_q       <= num_calc;
        issued_q    <= '0;
        completed_q <= '0;
        state_q     <= DISPATCH;
      end else if (state_q == DISPATCH && issued_q == num_q) begin
        state_q <= completed_q == num_q ? IDLE : DRAIN;
        done_q  <= completed_q == num_q;
      end else if (state_q == DRAIN && completed_q == num_q) begin
        state_q <= IDLE;
        done_q  <= 1'b1;
      end
    end
  end
`ifdef WAVE_DISPATCH_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else if (state_q != IDLE && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
  end
  assign perf_dispatch_cycles = perf_q;
`else
  assign perf_dispatch_cycles = '0;
`endif
endmodule

// File: tb/tb_wave_dispatcher.sv
// tb_wave_dispatcher: directed scenarios with a cycle-level reference model compared on every falling edge.
module tb_wave_dispatcher;
  localparam int N  = 4;
  localparam int WS = 32;
  logic clk = 1'b0;
  logic rst, enable, block_start;
  logic [31:0] block_id_in, block_dim;
  logic [N-1:0] simd_done;
  logic block_ready, block_done;
  logic [N-1:0] simd_ready, simd_start, simd_working;
  logic [32*N-1:0] wave_id;
  logic [31:0] block_id, num_waves_in_block, perf_dispatch_cycles;

  wave_dispatcher #(.NUM_SIMDS(N), .WAVE_SIZE(WS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .block_start(block_start),
    .block_id_in(block_id_in), .block_dim(block_dim), .block_ready(block_ready),
    .block_done(block_done), .simd_done(simd_done), .simd_ready(simd_ready),
    .simd_start(simd_start), .simd_working(simd_working), .wave_id(wave_id),
    .block_id(block_id), .num_waves_in_block(num_waves_in_block),
    .perf_dispatch_cycles(perf_dispatch_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 dispatch, 2 drain; SIMD 0 ready, 1 start, 2 working
  int m_state, nstate, hits;
  int m_simd [N];
  int nst [N];
  logic [31:0] m_wave [N];
  longint m_issued, m_completed, m_num, m_perf;
  logic [31:0] m_bid;
  bit m_done, ndone, issue_now;
  bit m_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_issued = 0; m_completed = 0; m_num = 0; m_perf = 0;
      m_bid = '0; m_done = 1'b0; m_valid = 1'b1;
      for (int i = 0; i < N; i++) begin m_simd[i] = 0; m_wave[i] = '0; end
    end else if (m_valid) begin
      hits = 0; issue_now = 1'b0; nstate = m_state; ndone = 1'b0;
      for (int i = 0; i < N; i++) begin
        nst[i] = m_simd[i];
        if (m_simd[i] == 1) nst[i] = 2;
        if (m_simd[i] == 2 && simd_done[i]) begin nst[i] = 0; hits++; end
      end
      if (m_state == 1 && enable && m_issued < m_num)
        for (int i = 0; i < N; i++)
          if (!issue_now && m_simd[i] == 0) begin
            nst[i] = 1; m_wave[i] = 32'(m_issued); issue_now = 1'b1;
          end
      if (m_state != 0 && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (m_state == 0 && block_start) begin
        m_bid = block_id_in;
        m_num = (longint'(block_dim) + WS - 1) / WS;
        m_issued = 0; m_completed = 0; nstate = 1;
      end else if (m_state == 1 && m_issued == m_num) begin
        ndone = m_completed == m_num;
        nstate = ndone ? 0 : 2;
      end else if (m_state == 2 && m_completed == m_num) begin
        ndone = 1'b1; nstate = 0;
      end
      m_issued += issue_now ? 1 : 0;
      m_completed += hits;
      m_state = nstate;
      m_done = ndone;
      for (int i = 0; i < N; i++) m_simd[i] = nst[i];
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      logic [N-1:0] er, es, ew;
      for (int i = 0; i < N; i++) begin
        er[i] = m_simd[i] == 0; es[i] = m_simd[i] == 1; ew[i] = m_simd[i] == 2;
        check($sformatf("model wave_id[%0d]", i), wave_id[32*i +: 32], m_wave[i]);
      end
      check("model simd_ready", 32'(simd_ready), 32'(er));
      check("model simd_start", 32'(simd_start), 32'(es));
      check("model simd_working", 32'(simd_working), 32'(ew));
      check("model block_ready", 32'(block_ready), 32'(m_state == 0));
      check("model block_done", 32'(block_done), 32'(m_done));
      check("model block_id", block_id, m_bid);
      check("model num_waves", num_waves_in_block, 32'(m_num));
`ifdef WAVE_DISPATCH_PERF_EN
      check("model perf", perf_dispatch_cycles, 32'(m_perf));
`else
      check("model perf", perf_dispatch_cycles, 32'd0);
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [31:0] id, input logic [31:0] dim);
    block_start = 1'b1; block_id_in = id; block_dim = dim;
    tick();
    block_start = 1'b0;
  endtask

  task automatic drain(input int max);
    bit seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      simd_done = simd_working;
      tick();
      seen = block_done;
    end
    simd_done = '0;
    check("drain block_done before timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; block_start = 1'b0;
    block_id_in = '0; block_dim = '0; simd_done = '0;
    tick(); tick();
    check("reset block_ready", 32'(block_ready), 32'd1);
    check("reset simd_ready", 32'(simd_ready), 32'hF);
    check("reset block_done", 32'(block_done), 32'd0);
    check("reset perf", perf_dispatch_cycles, 32'd0);
    check("reset num_waves", num_waves_in_block, 32'd0);
    rst = 1'b0;

    start_block(32'd7, 32'd64);
    check("dim64 num_waves", num_waves_in_block, 32'd2);
    check("dim64 block_id", block_id, 32'd7);
    tick();
    check("dim64 simd0 start", 32'(simd_start), 32'h1);
    check("dim64 wave0", wave_id[31:0], 32'd0);
    tick();
    check("dim64 simd1 start", 32'(simd_start), 32'h2);
    check("dim64 wave1", wave_id[63:32], 32'd1);
    tick();
    check("dim64 working", 32'(simd_working), 32'h3);
    simd_done = 4'b0011;
    tick();
    simd_done = '0;
    check("dim64 returned ready", 32'(simd_ready), 32'hF);
    check("dim64 no early done", 32'(block_done), 32'd0);
    tick();
    check("dim64 block_done pulse", 32'(block_done), 32'd1);
    tick();
    check("dim64 block_done cleared", 32'(block_done), 32'd0);

    start_block(32'd8, 32'd33);
    check("dim33 num_waves", num_waves_in_block, 32'd2);
    drain(20);

    start_block(32'd9, 32'd0);
    check("dim0 num_waves", num_waves_in_block, 32'd0);
    check("dim0 done not yet", 32'(block_done), 32'd0);
    check("dim0 no start c1", 32'(simd_start), 32'd0);
    tick();
    check("dim0 block_done", 32'(block_done), 32'd1);
    check("dim0 no start c2", 32'(simd_start), 32'd0);
    check("dim0 block_ready", 32'(block_ready), 32'd1);
    tick();

    start_block(32'd10, 32'd192);
    check("dim192 num_waves", num_waves_in_block, 32'd6);
    repeat (4) tick();
    for (int i = 0; i < N; i++) check($sformatf("dim192 wave slot %0d", i), wave_id[32*i +: 32], 32'(i));
    simd_done = 4'b0100;
    tick();
    check("dim192 simd2 ready", 32'(simd_ready), 32'h4);
    simd_done = 4'b0001;
    tick();
    simd_done = '0;
    check("dim192 simd2 start", 32'(simd_start), 32'h4);
    check("dim192 wave4 to simd2", wave_id[95:64], 32'd4);
    tick();
    check("dim192 simd0 start", 32'(simd_start), 32'h1);
    check("dim192 wave5 to simd0", wave_id[31:0], 32'd5);
    drain(30);

    start_block(32'd11, 32'd128);
    tick(); tick();
    enable = 1'b0;
    tick();
    check("stall working", 32'(simd_working), 32'h3);
    simd_done = 4'b0011;
    tick();
    simd_done = '0;
    check("stall done still handled", 32'(simd_ready), 32'hF);
    for (int k = 0; k < 3; k++) begin
      check("stall no start", 32'(simd_start), 32'd0);
      tick();
    end
    check("stall no start last", 32'(simd_start), 32'd0);
    enable = 1'b1;
    tick();
    check("resume start simd0", 32'(simd_start), 32'h1);
    check("resume wave2", wave_id[31:0], 32'd2);
    drain(30);

    start_block(32'd12, 32'd64);
    repeat (3) tick();
    block_start = 1'b1; block_id_in = 32'd55; block_dim = 32'd999;
    tick();
    block_start = 1'b0;
    check("drain start ignored id", block_id, 32'd12);
    check("drain start ignored num", num_waves_in_block, 32'd2);
    check("drain busy", 32'(block_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst simd_ready", 32'(simd_ready), 32'hF);
    check("midrst block_ready", 32'(block_ready), 32'd1);
    check("midrst block_done", 32'(block_done), 32'd0);
    check("midrst block_id", block_id, 32'd0);
    tick();
    check("midrst no late done", 32'(block_done), 32'd0);

    start_block(32'd13, 32'd64);
    repeat (8) tick();
    simd_done = 4'b0011;
    tick();
    simd_done = '0;
    tick();
    check("perf block_done", 32'(block_done), 32'd1);
`ifdef WAVE_DISPATCH_PERF_EN
    check("perf ten cycles", perf_dispatch_cycles, 32'd10);
`else
    check("perf disabled zero", perf_dispatch_cycles, 32'd0);
`endif
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
